// File: rtl/sysmem_arbiter_if.sv
// Bundle of the two requester ports (cpu, ld) and the shared BRAM lane bus.
// The arbiter connects through the slave modport; requesters and the memory
// model sit on the master side.
interface sysmem_arbiter_if #(
    parameter int ADDR_W = 10,
    parameter int LANES  = 4
);
    logic                  cpu_valid;
    logic [ADDR_W-1:0]     cpu_addr;
    logic [8*LANES-1:0]    cpu_wdata;
    logic [LANES-1:0]      cpu_wstrb;
    logic                  cpu_ready;
    logic [8*LANES-1:0]    cpu_rdata;

    logic                  ld_valid;
    logic [ADDR_W-1:0]     ld_addr;
    logic [8*LANES-1:0]    ld_wdata;
    logic [LANES-1:0]      ld_wstrb;
    logic                  ld_ready;
    logic [8*LANES-1:0]    ld_rdata;

    logic [ADDR_W-1:0]     mem_addr;
    logic [LANES-1:0]      mem_ce;
    logic [LANES-1:0]      mem_we;
    logic [8*LANES-1:0]    mem_di;
    logic [8*LANES-1:0]    mem_do;

    logic                  grant;

    modport slave (
        input  cpu_valid, cpu_addr, cpu_wdata, cpu_wstrb,
        output cpu_ready, cpu_rdata,
        input  ld_valid, ld_addr, ld_wdata, ld_wstrb,
        output ld_ready, ld_rdata,
        output mem_addr, mem_ce, mem_we, mem_di,
        input  mem_do,
        output grant
    );

    modport master (
        output cpu_valid, cpu_addr, cpu_wdata, cpu_wstrb,
        input  cpu_ready, cpu_rdata,
        output ld_valid, ld_addr, ld_wdata, ld_wstrb,
        input  ld_ready, ld_rdata,
        input  mem_addr, mem_ce, mem_we, mem_di,
        output mem_do,
        input  grant
    );
endinterface

// File: rtl/sysmem_arbiter.sv
// Two-port round-robin arbiter/sequencer for the system memory built from
// LANES byte-wide single-port BRAMs with unregistered outputs.
// Each access is IDLE -> ISSUE -> RESP: lane controls are registered in IDLE,
// the BRAM samples them at the end of ISSUE, and read data is forwarded
// combinationally from mem_do during RESP alongside the one-cycle ready.
module sysmem_arbiter #(
    parameter int ADDR_W = 10,
    parameter int LANES  = 4
) (
    input  logic               clk,
    input  logic               rst,
    sysmem_arbiter_if.slave    bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic                 grant_q, grant_d;   // 0 = cpu, 1 = ld
    logic                 last_q,  last_d;    // last served port
    logic                 rd_q,    rd_d;      // current access is a read
    logic [ADDR_W-1:0]    addr_q,  addr_d;
    logic [8*LANES-1:0]   di_q,    di_d;
    logic [LANES-1:0]     ce_q,    ce_d;
    logic [LANES-1:0]     we_q,    we_d;

    logic                 any_valid;
    logic                 win;
    logic [ADDR_W-1:0]    sel_addr;
    logic [8*LANES-1:0]   sel_wdata;
    logic [LANES-1:0]     sel_wstrb;
    logic                 cpu_rdy;
    logic                 ld_rdy;

    // Winner: a lone requester wins; on contention the port not served last.
    assign any_valid = bus.cpu_valid | bus.ld_valid;
    assign win       = (bus.cpu_valid && bus.ld_valid) ? ~last_q : bus.ld_valid;
    assign sel_addr  = win ? bus.ld_addr  : bus.cpu_addr;
    assign sel_wdata = win ? bus.ld_wdata : bus.cpu_wdata;
    assign sel_wstrb = win ? bus.ld_wstrb : bus.cpu_wstrb;

    // State and bus registers; reset drops any in-flight access.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            grant_q <= 1'b0;
            last_q  <= 1'b1;
            rd_q    <= 1'b0;
            addr_q  <= '0;
            di_q    <= '0;
            ce_q    <= '0;
            we_q    <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            last_q  <= last_d;
            rd_q    <= rd_d;
            addr_q  <= addr_d;
            di_q    <= di_d;
            ce_q    <= ce_d;
            we_q    <= we_d;
        end
    end

    // Next-state and registered lane controls for the access sequence.
    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        last_d  = last_q;
        rd_d    = rd_q;
        addr_d  = addr_q;
        di_d    = di_q;
        ce_d    = ce_q;
        we_d    = we_q;
        unique case (state_q)
            IDLE: begin
                ce_d = '0;
                we_d = '0;
                if (any_valid) begin
                    state_d = ISSUE;
                    grant_d = win;
                    last_d  = win;
                    addr_d  = sel_addr;
                    di_d    = sel_wdata;
                    if (sel_wstrb == '0) begin
                        rd_d = 1'b1;
                        ce_d = '1;
                        we_d = '0;
                    end else begin
                        rd_d = 1'b0;
                        ce_d = sel_wstrb;
                        we_d = sel_wstrb;
                    end
                end
            end
            ISSUE: begin
                ce_d    = '0;
                we_d    = '0;
                state_d = RESP;
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                ce_d    = '0;
                we_d    = '0;
            end
        endcase
    end

    assign cpu_rdy = (state_q == RESP) && !grant_q;
    assign ld_rdy  = (state_q == RESP) &&  grant_q;

    assign bus.cpu_ready = cpu_rdy;
    assign bus.ld_ready  = ld_rdy;
    assign bus.cpu_rdata = (cpu_rdy && rd_q) ? bus.mem_do : '0;
    assign bus.ld_rdata  = (ld_rdy  && rd_q) ? bus.mem_do : '0;

    assign bus.mem_addr  = addr_q;
    assign bus.mem_di    = di_q;
    assign bus.mem_ce    = ce_q;
    assign bus.mem_we    = we_q;
    assign bus.grant     = grant_q;

endmodule

// File: tb/tb_sysmem_arbiter.sv
// Bench for sysmem_arbiter: a byte-lane BRAM model on the memory side, a
// word-level reference memory, and per-scenario tasks.
module tb_sysmem_arbiter;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    sysmem_arbiter_if #(.ADDR_W(10), .LANES(4)) bus();

    sysmem_arbiter #(.ADDR_W(10), .LANES(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // BRAM lanes: synchronous, output registered one cycle after ce.
    logic [7:0]  bram [4][1024];
    logic [31:0] mem_do_q;
    assign bus.mem_do = mem_do_q;
    always @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (bus.mem_ce[i]) begin
                if (bus.mem_we[i]) bram[i][bus.mem_addr] <= bus.mem_di[8*i +: 8];
                else               mem_do_q[8*i +: 8]    <= bram[i][bus.mem_addr];
            end
        end
    end

    // Reference: word memory plus last-served port.
    logic [31:0] ref_mem [1024];
    bit          last_served;
    int          n_cmp  = 0;
    int          n_fail = 0;

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                          input logic [3:0] ws);
        logic [31:0] r;
        r = old;
        for (int i = 0; i < 4; i++) if (ws[i]) r[8*i +: 8] = wd[8*i +: 8];
        return r;
    endfunction

    task automatic idle_inputs();
        bus.cpu_valid = 1'b0; bus.cpu_addr = '0; bus.cpu_wdata = '0; bus.cpu_wstrb = '0;
        bus.ld_valid  = 1'b0; bus.ld_addr  = '0; bus.ld_wdata  = '0; bus.ld_wstrb  = '0;
    endtask

    task automatic drive_port(input bit port, input bit v, input logic [9:0] a,
                              input logic [31:0] wd, input logic [3:0] ws);
        if (!port) begin
            bus.cpu_valid = v; bus.cpu_addr = a; bus.cpu_wdata = wd; bus.cpu_wstrb = ws;
        end else begin
            bus.ld_valid = v; bus.ld_addr = a; bus.ld_wdata = wd; bus.ld_wstrb = ws;
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        idle_inputs();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        last_served = 1'b1;
    endtask

    // Single-requester access; returns data, latency and ISSUE-cycle bus view.
    task automatic access(input bit port, input logic [9:0] a, input logic [31:0] wd,
                          input logic [3:0] ws, output logic [31:0] rd, output int lat,
                          output logic [3:0] ce_i, output logic [3:0] we_i,
                          output logic [9:0] ad_i, output logic g_i, output bit other_bad);
        rd = '0; lat = -1; ce_i = '0; we_i = '0; ad_i = '0; g_i = 1'b0; other_bad = 1'b0;
        @(negedge clk);
        drive_port(port, 1'b1, a, wd, ws);
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            if (c == 1) begin
                ce_i = bus.mem_ce; we_i = bus.mem_we; ad_i = bus.mem_addr; g_i = bus.grant;
            end
            if (!port && (bus.ld_ready !== 1'b0 || bus.ld_rdata !== 32'h0)) other_bad = 1'b1;
            if ( port && (bus.cpu_ready !== 1'b0 || bus.cpu_rdata !== 32'h0)) other_bad = 1'b1;
            if ((!port && bus.cpu_ready === 1'b1) || (port && bus.ld_ready === 1'b1)) begin
                rd  = port ? bus.ld_rdata : bus.cpu_rdata;
                lat = c;
                break;
            end
        end
        drive_port(port, 1'b0, '0, '0, '0);
        if (lat > 0) begin
            last_served = port;
            if (ws != 4'h0) ref_mem[a] = merge(ref_mem[a], wd, ws);
        end
    endtask

    task automatic test_reset();
        do_reset();
        @(negedge clk);
        n_cmp++;
        if ({bus.cpu_ready, bus.ld_ready, bus.grant, bus.mem_ce, bus.mem_we} !== 11'h0) begin
            n_fail++;
            $display("FAIL reset_ctrl: got rdy/grant/ce/we=%b required 0",
                     {bus.cpu_ready, bus.ld_ready, bus.grant, bus.mem_ce, bus.mem_we});
        end
        n_cmp++;
        if ({bus.mem_addr, bus.mem_di, bus.cpu_rdata, bus.ld_rdata} !== '0) begin
            n_fail++;
            $display("FAIL reset_bus: addr=%h di=%h crd=%h lrd=%h required 0",
                     bus.mem_addr, bus.mem_di, bus.cpu_rdata, bus.ld_rdata);
        end
    endtask

    task automatic test_full_write();
        logic [31:0] rd; int lat; logic [3:0] ce, we; logic [9:0] ad; logic g; bit ob;
        access(1'b0, 10'h005, 32'hA1B2C3D4, 4'hF, rd, lat, ce, we, ad, g, ob);
        n_cmp++;
        if (ce !== 4'hF || we !== 4'hF || ad !== 10'h005) begin
            n_fail++;
            $display("FAIL wr_issue: ce=%h we=%h addr=%h required F F 005", ce, we, ad);
        end
        n_cmp++;
        if (lat !== 2) begin n_fail++; $display("FAIL wr_latency: got %0d required 2", lat); end
        n_cmp++;
        if (rd !== 32'h0 || ob) begin
            n_fail++; $display("FAIL wr_rdata: got %h other_bad=%0d required 0/0", rd, ob);
        end
        access(1'b0, 10'h005, '0, 4'h0, rd, lat, ce, we, ad, g, ob);
        n_cmp++;
        if (ce !== 4'hF || we !== 4'h0) begin
            n_fail++; $display("FAIL rd_issue: ce=%h we=%h required F 0", ce, we);
        end
        n_cmp++;
        if (rd !== ref_mem[10'h005] || lat !== 2) begin
            n_fail++;
            $display("FAIL rd_data: got %h lat %0d required %h lat 2", rd, lat, ref_mem[10'h005]);
        end
    endtask

    task automatic test_partial_write();
        logic [31:0] rd; int lat; logic [3:0] ce, we; logic [9:0] ad; logic g; bit ob;
        access(1'b1, 10'h005, 32'h000000EE, 4'b0001, rd, lat, ce, we, ad, g, ob);
        n_cmp++;
        if (ce !== 4'b0001 || we !== 4'b0001 || g !== 1'b1 || ob) begin
            n_fail++;
            $display("FAIL part_issue: ce=%b we=%b grant=%b other_bad=%0d required 0001 0001 1 0",
                     ce, we, g, ob);
        end
        access(1'b0, 10'h005, '0, 4'h0, rd, lat, ce, we, ad, g, ob);
        n_cmp++;
        if (rd !== 32'hA1B2C3EE) begin
            n_fail++; $display("FAIL part_read: got %h required a1b2c3ee", rd);
        end
    endtask

    task automatic test_contention();
        int  c_at, l_at; logic g1, g4; bit dbl;
        logic [31:0] c_rd, l_rd;
        do_reset();
        c_at = -1; l_at = -1; g1 = 1'bx; g4 = 1'bx; dbl = 1'b0; c_rd = 'x; l_rd = 'x;
        @(negedge clk);
        drive_port(1'b0, 1'b1, 10'h005, 32'h0, 4'h0);
        drive_port(1'b1, 1'b1, 10'h005, 32'h0, 4'h0);
        for (int c = 1; c <= 12; c++) begin
            @(negedge clk);
            if (c == 1) g1 = bus.grant;
            if (c == 4) g4 = bus.grant;
            if (bus.cpu_ready === 1'b1 && bus.ld_ready === 1'b1) dbl = 1'b1;
            if (bus.cpu_ready === 1'b1) begin
                if (c_at < 0) c_at = c; else dbl = 1'b1;
                c_rd = bus.cpu_rdata; drive_port(1'b0, 1'b0, '0, '0, '0);
            end
            if (bus.ld_ready === 1'b1) begin
                if (l_at < 0) l_at = c; else dbl = 1'b1;
                l_rd = bus.ld_rdata; drive_port(1'b1, 1'b0, '0, '0, '0);
            end
        end
        last_served = 1'b1;
        n_cmp++;
        if (c_at !== 2 || l_at !== 5) begin
            n_fail++; $display("FAIL cont_order: cpu@%0d ld@%0d required cpu@2 ld@5", c_at, l_at);
        end
        n_cmp++;
        if (g1 !== 1'b0 || g4 !== 1'b1 || dbl) begin
            n_fail++; $display("FAIL cont_grant: g=%b,%b double=%0d required 0,1,0", g1, g4, dbl);
        end
        n_cmp++;
        if (c_rd !== ref_mem[10'h005] || l_rd !== ref_mem[10'h005]) begin
            n_fail++;
            $display("FAIL cont_data: cpu %h ld %h required %h", c_rd, l_rd, ref_mem[10'h005]);
        end
    endtask

    // Both ports always requesting: cpu random reads, ld random reads/writes.
    task automatic test_back_to_back();
        logic [31:0] rd; int lat; logic [3:0] ce, we; logic [9:0] ad; logic g; bit ob;
        logic [9:0]  p_a  [2];
        logic [31:0] p_wd [2];
        logic [3:0]  p_ws [2];
        int          age  [2];
        int          cpu_done, bad_order, bad_data, bad_lat, cyc;
        bit          port, exp_port, dbl;
        logic [31:0] got, exp;
        for (int a = 0; a < 8; a++)
            access(1'b1, 10'(a), $urandom, 4'hF, rd, lat, ce, we, ad, g, ob);
        cpu_done = 0; bad_order = 0; bad_data = 0; bad_lat = 0; dbl = 1'b0; cyc = 0;
        @(negedge clk);
        for (int p = 0; p < 2; p++) begin
            p_a[p]  = 10'($urandom_range(7));
            p_wd[p] = $urandom;
            p_ws[p] = (p == 0) ? 4'h0 : 4'($urandom_range(15));
            age[p]  = 0;
            drive_port(p[0], 1'b1, p_a[p], p_wd[p], p_ws[p]);
        end
        while (cpu_done < 10 && cyc < 200) begin
            @(negedge clk);
            cyc++;
            age[0]++; age[1]++;
            if (bus.cpu_ready === 1'b1 && bus.ld_ready === 1'b1) dbl = 1'b1;
            if (bus.cpu_ready === 1'b1 || bus.ld_ready === 1'b1) begin
                port     = (bus.ld_ready === 1'b1);
                exp_port = ~last_served;
                if (port !== exp_port) bad_order++;
                got = port ? bus.ld_rdata : bus.cpu_rdata;
                exp = (p_ws[port] == 4'h0) ? ref_mem[p_a[port]] : 32'h0;
                if (got !== exp) begin
                    bad_data++;
                    $display("FAIL b2b_data: port %0d addr %h got %h required %h",
                             port, p_a[port], got, exp);
                end
                if (age[port] > 6) bad_lat++;
                if (p_ws[port] != 4'h0)
                    ref_mem[p_a[port]] = merge(ref_mem[p_a[port]], p_wd[port], p_ws[port]);
                last_served = port;
                if (!port) cpu_done++;
                p_a[port]  = 10'($urandom_range(7));
                p_wd[port] = $urandom;
                p_ws[port] = port ? 4'($urandom_range(15)) : 4'h0;
                age[port]  = 0;
                drive_port(port, 1'b1, p_a[port], p_wd[port], p_ws[port]);
            end
        end
        // Let the in-flight ld access finish so later tests start from IDLE.
        drive_port(1'b0, 1'b0, '0, '0, '0);
        for (int c = 0; c < 8 && bus.ld_ready !== 1'b1; c++) @(negedge clk);
        if (bus.ld_ready === 1'b1) begin
            if (p_ws[1] != 4'h0) ref_mem[p_a[1]] = merge(ref_mem[p_a[1]], p_wd[1], p_ws[1]);
            last_served = 1'b1;
        end
        drive_port(1'b1, 1'b0, '0, '0, '0);
        n_cmp++;
        if (cpu_done !== 10) begin
            n_fail++; $display("FAIL b2b_timeout: cpu completions %0d required 10", cpu_done);
        end
        n_cmp++;
        if (bad_order !== 0 || dbl) begin
            n_fail++; $display("FAIL b2b_alternate: bad %0d double %0d required 0", bad_order, dbl);
        end
        n_cmp++;
        if (bad_data !== 0) begin
            n_fail++; $display("FAIL b2b_rdata: bad %0d required 0", bad_data);
        end
        n_cmp++;
        if (bad_lat !== 0) begin
            n_fail++; $display("FAIL b2b_latency: over-6 count %0d required 0", bad_lat);
        end
    endtask

    task automatic test_reset_mid_access();
        logic [31:0] rd; int lat; logic [3:0] ce, we; logic [9:0] ad; logic g; bit ob, seen;
        @(negedge clk);
        drive_port(1'b0, 1'b1, 10'h005, '0, 4'h0);
        @(negedge clk);
        rst = 1'b1;
        idle_inputs();
        @(negedge clk);
        rst = 1'b0;
        last_served = 1'b1;
        n_cmp++;
        if ({bus.mem_ce, bus.mem_we, bus.cpu_ready, bus.grant} !== 10'h0 || bus.mem_addr !== 10'h0) begin
            n_fail++;
            $display("FAIL midrst_clear: ce=%h we=%h rdy=%b grant=%b addr=%h required 0",
                     bus.mem_ce, bus.mem_we, bus.cpu_ready, bus.grant, bus.mem_addr);
        end
        seen = 1'b0;
        repeat (4) begin
            @(negedge clk);
            if (bus.cpu_ready !== 1'b0 || bus.mem_ce !== 4'h0) seen = 1'b1;
        end
        n_cmp++;
        if (seen) begin n_fail++; $display("FAIL midrst_noready: activity seen required none"); end
        access(1'b0, 10'h005, '0, 4'h0, rd, lat, ce, we, ad, g, ob);
        n_cmp++;
        if (rd !== ref_mem[10'h005] || lat !== 2) begin
            n_fail++;
            $display("FAIL midrst_fresh: got %h lat %0d required %h lat 2", rd, lat, ref_mem[10'h005]);
        end
    endtask

    task automatic test_boundary();
        logic [31:0] rd; int lat; logic [3:0] ce, we; logic [9:0] ad; logic g; bit ob;
        access(1'b1, 10'h000, 32'hCAFEF00D, 4'hF, rd, lat, ce, we, ad, g, ob);
        access(1'b0, 10'h3FF, 32'h12345678, 4'hF, rd, lat, ce, we, ad, g, ob);
        n_cmp++;
        if (ad !== 10'h3FF) begin n_fail++; $display("FAIL top_addr: got %h required 3ff", ad); end
        access(1'b1, 10'h3FF, '0, 4'h0, rd, lat, ce, we, ad, g, ob);
        n_cmp++;
        if (rd !== 32'h12345678) begin
            n_fail++; $display("FAIL top_read: got %h required 12345678", rd);
        end
        access(1'b0, 10'h000, '0, 4'h0, rd, lat, ce, we, ad, g, ob);
        n_cmp++;
        if (rd !== 32'hCAFEF00D) begin
            n_fail++; $display("FAIL low_intact: got %h required cafef00d", rd);
        end
    endtask

    initial begin
        idle_inputs();
        for (int i = 0; i < 1024; i++) ref_mem[i] = 32'h0;
        test_reset();
        test_full_write();
        test_partial_write();
        test_contention();
        test_back_to_back();
        test_reset_mid_access();
        test_boundary();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
